// File: rtl/ddr_rx_deframer.sv
// ddr_rx_deframer
//   Takes the 2-bit-per-cycle output of a DDR capture register and aligns to a
//   start-of-frame marker. It assembles DATA_WIDTH-bit words LSB-first, with the
//   first pair in bits [1:0]. Each finished word goes into a single-entry holding
//   register with a valid/ready handshake. If a word finishes while the holding
//   register is full, the word is dropped and the loss is reported.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   en          : capture enable; low forces idle and discards any partial word
//   ddr_din     : bit0 = older (falling-edge) sample, bit1 = newer (rising-edge)
//   sof         : marks ddr_din as the first pair of a word
//   dout        : assembled word
//   dout_vld    : holding register contains an unconsumed word
//   dout_rd     : consumer ready; a transfer happens on dout_vld & dout_rd
//   busy        : high while words are being shifted in
//   overflow    : sticky; a completed word was dropped
//   align_err   : sticky; sof arrived mid-word
//   clr_err     : clears the sticky flags (a same-cycle set still wins)
module ddr_rx_deframer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            ddr_din,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rd,
    output logic                  busy,
    output logic                  overflow,
    output logic                  align_err,
    input  logic                  clr_err
);

    localparam int unsigned PAIRS = DATA_WIDTH / 2;
    localparam int unsigned CntW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PAIRS - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StHunt, StShift} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] slot_word;
    logic [DATA_WIDTH-1:0] first_pair;
    logic                  resync;

    // Shift register with the incoming pair dropped into the current slot.
    // On the last slot this is the completed word.
    always_comb begin
        slot_word = shreg_q;
        slot_word[2 * int'(cnt_q) +: 2] = ddr_din;
    end

    // Starting a new word from slot 0 discards whatever partial word was there.
    assign first_pair = {{(DATA_WIDTH - 2){1'b0}}, ddr_din};
    assign resync     = (state_q == StShift) && en && sof && (cnt_q != '0);
    assign busy       = (state_q == StShift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            // Defaults first. A later assignment in this block overrides them,
            // so a same-cycle set or a new completion wins.
            if (clr_err) begin
                overflow  <= 1'b0;
                align_err <= 1'b0;
            end
            if (dout_vld && dout_rd) begin
                dout_vld <= 1'b0;
            end

            if (!en) begin
                // The holding register is left alone, so a pending word stays readable.
                state_q <= StIdle;
                cnt_q   <= '0;
                shreg_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StHunt;
                    end
                    StHunt: begin
                        if (sof) begin
                            shreg_q <= first_pair;
                            cnt_q   <= CntOne;
                            state_q <= StShift;
                        end
                    end
                    StShift: begin
                        if (resync) begin
                            shreg_q   <= first_pair;
                            cnt_q     <= CntOne;
                            align_err <= 1'b1;
                        end else begin
                            shreg_q <= slot_word;
                            if (cnt_q == CntLast) begin
                                cnt_q <= '0;
                                // A word can be accepted while a read empties the holding register.
                                if (!dout_vld || dout_rd) begin
                                    dout     <= slot_word;
                                    dout_vld <= 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CntOne;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
